caliptra_prim_present_iter: RTL

CALIPTRA_PRIM_PRESENT_ITER -- requirements
Module: caliptra_prim_present_iter

---
 rtl/caliptra_prim_present_iter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/caliptra_prim_present_iter.sv
// Iterative PRESENT block cipher: NumPhysRounds rounds per clock. Decryption
// first runs the forward key schedule to reach the last round key.
module caliptra_prim_present_iter #(
    parameter int DataWidth     = 64,
    parameter int KeyWidth      = 128,
    parameter int NumRounds     = 31,
    parameter int NumPhysRounds = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_decrypt_i,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic [KeyWidth-1:0]  req_key_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 busy_o
);

    localparam int R = NumRounds / NumPhysRounds;
    localparam int CtrLsb = (KeyWidth == 128) ? 62 : 15;
    localparam logic [4:0] LastCnt = 5'(R - 1);
    localparam logic [4:0] LastIdx = 5'(NumRounds);

    localparam logic [15:0][3:0] SBOX = {4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
                                         4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC};
    localparam logic [15:0][3:0] SBOX_INV = {4'hA, 4'h9, 4'h7, 4'h0, 4'h3, 4'h6, 4'h4, 4'hB,
                                             4'hD, 4'h2, 4'h1, 4'hC, 4'h8, 4'hF, 4'hE, 4'h5};

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] data_q, data_d, data_rnd;
    logic [KeyWidth-1:0]  key_q, key_d, key_rnd;
    logic [4:0]           idx_q, idx_d, idx_rnd;
    logic [4:0]           cnt_q, cnt_d;
    logic                 dec_q, dec_d;

    function automatic logic [DataWidth-1:0] sbox_layer(logic [DataWidth-1:0] s, logic inv);
        logic [DataWidth-1:0] o;
        o = s;
        for (int i = 0; i < DataWidth / 4; i++)
            o[4*i +: 4] = inv ? SBOX_INV[s[4*i +: 4]] : SBOX[s[4*i +: 4]];
        return o;
    endfunction

    // Bit i moves to i*DataWidth/4 mod (DataWidth-1); the MSB is a fixed point.
    function automatic logic [DataWidth-1:0] perm_layer(logic [DataWidth-1:0] s, logic inv);
        logic [DataWidth-1:0] o;
        o = s;
        for (int i = 0; i < DataWidth - 1; i++) begin
            if (inv) o[i] = s[(i * DataWidth / 4) % (DataWidth - 1)];
            else     o[(i * DataWidth / 4) % (DataWidth - 1)] = s[i];
        end
        return o;
    endfunction

    function automatic logic [KeyWidth-1:0] key_fwd(logic [KeyWidth-1:0] k, logic [4:0] idx);
        logic [KeyWidth-1:0] o;
        o = (k << 61) | (k >> (KeyWidth - 61));
        o[KeyWidth-1 -: 4] = SBOX[o[KeyWidth-1 -: 4]];
        if (KeyWidth == 128) o[KeyWidth-5 -: 4] = SBOX[o[KeyWidth-5 -: 4]];
        o[CtrLsb +: 5] = o[CtrLsb +: 5] ^ idx;
        return o;
    endfunction

    function automatic logic [KeyWidth-1:0] key_inv(logic [KeyWidth-1:0] k, logic [4:0] idx);
        logic [KeyWidth-1:0] o;
        o = k;
        o[CtrLsb +: 5] = o[CtrLsb +: 5] ^ idx;
        o[KeyWidth-1 -: 4] = SBOX_INV[o[KeyWidth-1 -: 4]];
        if (KeyWidth == 128) o[KeyWidth-5 -: 4] = SBOX_INV[o[KeyWidth-5 -: 4]];
        o = (o >> 61) | (o << (KeyWidth - 61));
        return o;
    endfunction

    // Unrolled datapath shared by key expansion, encryption and decryption.
    always_comb begin
        data_rnd = data_q;
        key_rnd  = key_q;
        idx_rnd  = idx_q;
        for (int r = 0; r < NumPhysRounds; r++) begin
            if (state_q == KEYEXP) begin
                key_rnd = key_fwd(key_rnd, idx_rnd);
                idx_rnd = idx_rnd + 5'd1;
            end else if (dec_q) begin
                data_rnd = sbox_layer(perm_layer(data_rnd, 1'b1), 1'b1);
                key_rnd  = key_inv(key_rnd, idx_rnd);
                data_rnd = data_rnd ^ key_rnd[KeyWidth-1 -: DataWidth];
                idx_rnd  = idx_rnd - 5'd1;
            end else begin
                data_rnd = perm_layer(sbox_layer(data_rnd ^ key_rnd[KeyWidth-1 -: DataWidth], 1'b0), 1'b0);
                key_rnd  = key_fwd(key_rnd, idx_rnd);
                idx_rnd  = idx_rnd + 5'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                data_d  = req_data_i;
                key_d   = req_key_i;
                dec_d   = req_decrypt_i;
                idx_d   = 5'd1;
                cnt_d   = 5'd0;
                state_d = req_decrypt_i ? KEYEXP : ROUND;
            end
            KEYEXP: begin
                key_d = key_rnd;
                idx_d = idx_rnd;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LastCnt) begin
                    data_d  = data_q ^ key_rnd[KeyWidth-1 -: DataWidth];
                    idx_d   = LastIdx;
                    cnt_d   = 5'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                data_d = data_rnd;
                key_d  = key_rnd;
                idx_d  = idx_rnd;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == LastCnt) begin
                    cnt_d   = 5'd0;
                    state_d = DONE;
                    // Whitening with the final round key happens exactly once.
                    if (!dec_q) data_d = data_rnd ^ key_rnd[KeyWidth-1 -: DataWidth];
                end
            end
            DONE: if (rsp_ready_i) begin
                data_d  = '0;
                key_d   = '0;
                idx_d   = '0;
                dec_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            data_d  = '0;
            key_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
            dec_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == DONE);
    assign rsp_data_o  = rsp_valid_o ? data_q : '0;
    assign busy_o      = (state_q != IDLE);

endmodule
